// File: rtl/softmax_feeder.sv
// Streams a vector from the input memory through a 4-lane softmax engine in
// groups of four elements and writes each group's results to the output memory.
module softmax_feeder #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [AWIDTH-1:0]     len,
    output logic                  busy,
    output logic                  finish,
    output logic                  err,
    output logic [AWIDTH-1:0]     rd_addr,
    input  logic [DWIDTH-1:0]     rd_data,
    output logic                  wr_en,
    output logic [AWIDTH-1:0]     wr_addr,
    output logic [DWIDTH-1:0]     wr_data,
    output logic                  sm_start,
    output logic [4*DWIDTH-1:0]   sm_inp,
    input  logic [4*DWIDTH-1:0]   sm_outp,
    input  logic                  sm_done,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE, FETCH, START, WAIT, CAPTURE, WRITE, FIN
    } state_t;

    localparam int GW = AWIDTH - 2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_t              state, state_next;
    logic [2:0]          k;
    logic [GW-1:0]       g, g_last;
    logic [CW-1:0]       wait_cnt;
    logic [DWIDTH-1:0]   in_lane  [4];
    logic [DWIDTH-1:0]   out_lane [4];

    // Handshake: rd_addr in cycle t returns rd_data in t+1; sm_start is a
    // single-cycle pulse and sm_done is honoured only while in WAIT.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = (len[AWIDTH-1:2] == '0) ? FIN : FETCH;
            FETCH:   if (k == 3'd4) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (sm_done)                 state_next = CAPTURE;
                else if (wait_cnt == TO_CNT) state_next = FIN;
            end
            CAPTURE: state_next = WRITE;
            WRITE:   if (k == 3'd3) state_next = (g == g_last) ? FIN : FETCH;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k        <= '0;
            g        <= '0;
            g_last   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_lane[i]  <= '0;
                out_lane[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    k <= '0;
                    if (go) begin
                        err    <= |len[1:0];
                        g      <= '0;
                        g_last <= len[AWIDTH-1:2] - GW'(1);
                    end
                end
                FETCH: begin
                    // Data for address k arrives one cycle later, so lane k-1 fills at step k.
                    if (k != 3'd0) in_lane[k[1:0] - 2'd1] <= rd_data;
                    k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
                end
                START: wait_cnt <= CW'(1);
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (!sm_done && wait_cnt == TO_CNT) err <= 1'b1;
                end
                CAPTURE: begin
                    k <= '0;
                    for (int i = 0; i < 4; i++)
                        out_lane[i] <= sm_outp[i*DWIDTH +: DWIDTH];
                end
                WRITE: begin
                    if (k == 3'd3) begin
                        k <= '0;
                        if (g != g_last) g <= g + GW'(1);
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: k <= '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            sm_inp[i*DWIDTH +: DWIDTH] = in_lane[i];
    end

    assign busy      = (state != IDLE);
    assign finish    = (state == FIN);
    assign sm_start  = (state == START);
    assign wr_en     = (state == WRITE);
    assign rd_addr   = (state == FETCH && k != 3'd4) ? {g, k[1:0]} : '0;
    assign wr_addr   = wr_en ? {g, k[1:0]} : '0;
    assign wr_data   = wr_en ? out_lane[k[1:0]] : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_softmax_feeder.sv
// Directed bench for softmax_feeder: memory and engine models, write
// scoreboard, latency and flag checks, and a single summary line.
module tb_softmax_feeder;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 15;
    localparam int W  = AW + DW;

    logic              clk;
    logic              reset;
    logic              go;
    logic [AW-1:0]     len;
    logic              busy, finish, err;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              sm_start;
    logic [4*DW-1:0]   sm_inp;
    logic [4*DW-1:0]   sm_outp;
    logic              sm_done;
    logic [2:0]        dbg_state;

    softmax_feeder #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .go(go), .len(len),
        .busy(busy), .finish(finish), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sm_start(sm_start), .sm_inp(sm_inp), .sm_outp(sm_outp),
        .sm_done(sm_done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;
    int n_fin    = 0;
    int done_delay = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic [DW-1:0] mem [0:255];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] eng_f(input logic [DW-1:0] x, input int lane);
        return x + (32'h0010_0000 * 32'(lane + 1));
    endfunction

    // input memory with one cycle of read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    // engine model: done and results appear done_delay cycles after start
    initial begin
        logic [4*DW-1:0] inp;
        sm_done = 1'b0;
        sm_outp = '0;
        forever begin
            @(negedge clk);
            if (sm_start === 1'b1 && done_delay > 0) begin
                inp = sm_inp;
                repeat (done_delay) @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++)
                    sm_outp[i*DW +: DW] = eng_f(inp[i*DW +: DW], i);
                sm_done = 1'b1;
                @(posedge clk);
                #1 sm_done = 1'b0;
            end
        end
    end

    // monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en)    act_q.push_back({wr_addr, wr_data});
            if (sm_start) n_start++;
            if (finish)   n_fin++;
        end
    end

    // driver: one vector, then latency, flag and write-stream checks
    task automatic run_vec(input string tag, input int l, input int d, input int exp_lat,
                           input logic exp_err, input int exp_starts, input int exp_groups);
        int s0, f0, lat, addr;
        logic [W-1:0] e, a;
        done_delay = d;
        act_q.delete();
        exp_q.delete();
        for (int gi = 0; gi < exp_groups; gi++)
            for (int ki = 0; ki < 4; ki++) begin
                addr = 4 * gi + ki;
                exp_q.push_back({AW'(addr), eng_f(mem[addr], ki)});
            end
        s0 = n_start;
        f0 = n_fin;
        @(negedge clk);
        go  = 1'b1;
        len = AW'(l);
        @(posedge clk);
        #1 go = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (finish) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check({tag, "_starts"}, 64'(n_start - s0), 64'(exp_starts));
        check({tag, "_finish"}, 64'(n_fin - f0), 64'd1);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            check({tag, "_write"}, 64'(a), 64'(e));
        end
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int cnt, s0, f0, sz;
        for (int i = 0; i < 256; i++) mem[i] = 32'h3C00_0000 + 32'(i) * 32'h0001_0307;
        mem[0] = 32'h3F80_0000;
        mem[1] = 32'h4000_0000;
        mem[2] = 32'h4040_0000;
        mem[3] = 32'h4080_0000;

        reset = 1'b1;
        go    = 1'b0;
        len   = '0;
        repeat (3) @(negedge clk);
        check("rst_state",    64'(dbg_state), 64'd0);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_finish",   64'(finish),    64'd0);
        check("rst_err",      64'(err),       64'd0);
        check("rst_wr_en",    64'(wr_en),     64'd0);
        check("rst_sm_start", 64'(sm_start),  64'd0);
        check("rst_rd_addr",  64'(rd_addr),   64'd0);
        check("rst_wr_addr",  64'(wr_addr),   64'd0);
        check("rst_wr_data",  64'(wr_data),   64'd0);
        check("rst_lanes_lo", sm_inp[63:0],   64'd0);
        check("rst_lanes_hi", sm_inp[127:64], 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // latency = G*(5+1+D+1+4)+1
        run_vec("len4",   4,  7, 19, 1'b0, 1, 1);
        run_vec("len12", 12,  3, 43, 1'b0, 3, 3);
        run_vec("len6",   6,  5, 17, 1'b1, 1, 1);
        run_vec("len0",   0,  3,  1, 1'b0, 0, 0);
        run_vec("tmo",    4,  0, 6 + TO + 1, 1'b1, 1, 0);
        run_vec("post_tmo", 4, 2, 14, 1'b0, 1, 1);
        run_vec("len255", 255, 1, 63 * 12 + 1, 1'b1, 63, 63);

        // reset in the middle of group 1's write burst
        done_delay = 2;
        @(negedge clk);
        go  = 1'b1;
        len = AW'(8);
        @(posedge clk);
        #1 go = 1'b0;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (wr_en && wr_addr == AW'(4)) break;
        end
        check("midrst_reach", 64'(cnt < 200), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", 64'(wr_en),     64'd0);
        check("midrst_busy",  64'(busy),      64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        s0 = n_start;
        f0 = n_fin;
        sz = act_q.size();
        repeat (20) @(negedge clk);
        check("midrst_nofin",   64'(n_fin - f0),         64'd0);
        check("midrst_nostart", 64'(n_start - s0),       64'd0);
        check("midrst_nowrite", 64'(act_q.size() - sz),  64'd0);
        check("midrst_idle",    64'(busy),               64'd0);
        run_vec("after_rst", 4, 4, 16, 1'b0, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
